// File: rtl/sap1_pkg.sv
// Shared SAP-1 definitions: default address width and the address type.
package sap1_pkg;

  localparam int unsigned SAP1_ADDR_WIDTH = 4;

  typedef logic [SAP1_ADDR_WIDTH-1:0] sap1_addr_t;

endpackage : sap1_pkg

// File: rtl/sap1_bus_driver.sv
// Parameterised tri-state buffer used by every W-bus source.
module sap1_bus_driver #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Drive d onto the bus while enabled, otherwise release it.
  assign q = en ? d : 'z;

endmodule : sap1_bus_driver

// File: rtl/sap1_program_counter.sv
// SAP-1 program counter: counts on the falling clock edge when Cp is high
// and places its value on the W bus while Ep is high.
module sap1_program_counter
  import sap1_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = SAP1_ADDR_WIDTH
) (
  input  logic                  CLK_n,
  input  logic                  CLR_n,
  input  logic                  Cp,
  input  logic                  Ep,
  output logic [ADDR_WIDTH-1:0] w_bus_addr
);

  logic [ADDR_WIDTH-1:0] count;

  // Counter register: asynchronous clear, increment on falling edge when
  // enabled; wraps naturally modulo 2^ADDR_WIDTH with no carry out.
  always_ff @(negedge CLK_n or negedge CLR_n) begin
    if (!CLR_n) begin
      count <= '0;
    end else if (Cp) begin
      count <= count + 1'b1;
    end
  end

  sap1_bus_driver #(
    .WIDTH (ADDR_WIDTH)
  ) u_bus_driver (
    .en (Ep),
    .d  (count),
    .q  (w_bus_addr)
  );

endmodule : sap1_program_counter

// File: tb/tb_sap1_program_counter.sv
// Directed bench for sap1_program_counter. Two identical DUTs share all
// inputs; one drives a pulled-up net and the other a pulled-down net, so a
// released bus reads all ones on the first and all zeros on the second.
module tb_sap1_program_counter;

  logic clk_n;
  logic clr_n;
  logic cp;
  logic ep;

  tri1 [3:0] bus_pu;
  tri0 [3:0] bus_pd;

  int total;
  int bad;

  sap1_program_counter #(.ADDR_WIDTH(4)) dut_pu (
    .CLK_n      (clk_n),
    .CLR_n      (clr_n),
    .Cp         (cp),
    .Ep         (ep),
    .w_bus_addr (bus_pu)
  );

  sap1_program_counter #(.ADDR_WIDTH(4)) dut_pd (
    .CLK_n      (clk_n),
    .CLR_n      (clr_n),
    .Cp         (cp),
    .Ep         (ep),
    .w_bus_addr (bus_pd)
  );

  initial clk_n = 1'b1;
  always #5 clk_n = ~clk_n;

  // Wait for the active (falling) edge and sample just after it.
  task automatic edge_step();
    @(negedge clk_n);
    #1;
  endtask

  // driven=1: both nets must show exp; driven=0: bus must be released.
  task automatic chk(input string tag, input logic driven, input logic [3:0] exp);
    total++;
    if (driven) begin
      assert (bus_pu === exp && bus_pd === exp)
      else begin
        bad++;
        $error("FAIL %s: observed pu=%h pd=%h expected %h", tag, bus_pu, bus_pd, exp);
      end
    end else begin
      assert (bus_pu === 4'hF && bus_pd === 4'h0)
      else begin
        bad++;
        $error("FAIL %s: observed pu=%h pd=%h expected released (z)", tag, bus_pu, bus_pd);
      end
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: observed timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    total = 0;
    bad   = 0;
    clr_n = 1'b0;
    cp    = 1'b0;
    ep    = 1'b0;

    // Reset state, both output-enable settings.
    #2;
    chk("reset_ep0", 1'b0, 4'h0);
    ep = 1'b1;
    #1;
    chk("reset_ep1", 1'b1, 4'h0);
    ep = 1'b0;
    edge_step();
    clr_n = 1'b1;

    // Idle: bus released, count unchanged.
    for (int i = 0; i < 3; i++) begin
      edge_step();
      chk($sformatf("idle_%0d", i), 1'b0, 4'h0);
    end
    ep = 1'b1;
    #1;
    chk("idle_count_held", 1'b1, 4'h0);

    // Count five edges.
    cp = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      edge_step();
      chk($sformatf("count_%0d", i), 1'b1, 4'(i));
    end

    // Mid-cycle asynchronous clear, no clock edge needed.
    cp = 1'b0;
    #2;
    clr_n = 1'b0;
    #1;
    chk("async_clear", 1'b1, 4'h0);
    clr_n = 1'b1;
    #1;
    chk("clear_release_hold", 1'b1, 4'h0);

    // Wrap: 16 edges from 0; the 16th returns to 0.
    cp = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      edge_step();
      chk($sformatf("wrap_%0d", i), 1'b1, 4'(i % 16));
    end

    // Advance to 7, then hold and toggle Ep.
    for (int i = 1; i <= 7; i++) edge_step();
    chk("reach_7", 1'b1, 4'h7);
    cp = 1'b0;
    edge_step();
    chk("hold_7", 1'b1, 4'h7);
    ep = 1'b0;
    #1;
    chk("hold_ep0", 1'b0, 4'h0);
    edge_step();
    ep = 1'b1;
    #1;
    chk("hold_ep1", 1'b1, 4'h7);

    // Cp pulse that does not span a falling edge has no effect.
    cp = 1'b1;
    #2;
    cp = 1'b0;
    edge_step();
    chk("short_cp_pulse", 1'b1, 4'h7);

    // Re-enable counting.
    cp = 1'b1;
    edge_step();
    chk("resume_8", 1'b1, 4'h8);

    // Counting with Ep low still advances the register.
    ep = 1'b0;
    edge_step();
    chk("count_ep0_bus", 1'b0, 4'h0);
    ep = 1'b1;
    #1;
    chk("count_ep0_value", 1'b1, 4'h9);

    // Reset priority over Cp across falling edges.
    clr_n = 1'b0;
    edge_step();
    chk("clr_prio_1", 1'b1, 4'h0);
    edge_step();
    chk("clr_prio_2", 1'b1, 4'h0);
    #2;
    clr_n = 1'b1;
    #1;
    chk("clr_release", 1'b1, 4'h0);
    edge_step();
    chk("after_clr_1", 1'b1, 4'h1);
    edge_step();
    chk("after_clr_2", 1'b1, 4'h2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_sap1_program_counter
